// File: rtl/agc_tpgen_stage.sv
// Time-pulse ring (T01..T12) and instruction stage register for the sequence generator.
// The stage transfer happens only on the advance that takes the ring from T12 to T01.
module agc_tpgen_stage #(
  parameter int unsigned NTP = 12
) (
  input  logic           CLOCK,
  input  logic           rst,
  input  logic           RUN,
  input  logic           SSTEP,
  input  logic           INSTOP,
  input  logic           GOJAM,
  input  logic           ST1D,
  input  logic           ST2D,
  output logic [NTP-1:0] TP_,
  output logic           T01_,
  output logic           T02,
  output logic           T07_,
  output logic           T12_,
  output logic           ST0_,
  output logic           ST1_,
  output logic           ST3_,
  output logic           STD2,
  output logic           MCTEND,
  output logic           STOPPED
);

  localparam logic [NTP-1:0] RING_T01 = {{(NTP-1){1'b0}}, 1'b1};
  localparam logic [NTP-1:0] RING_T12 = {1'b1, {(NTP-1){1'b0}}};

  typedef enum logic [1:0] {
    STAGE0 = 2'd0,
    STAGE1 = 2'd1,
    STAGE2 = 2'd2,
    STAGE3 = 2'd3
  } stage_e;

  logic [NTP-1:0] ring_q, ring_d;
  stage_e         st_q, st_d;
  logic           pend1_q, pend1_d;
  logic           pend2_q, pend2_d;
  logic           mctend_q, mctend_d;
  logic           fresh_q, fresh_d;

  logic ring_legal;
  logic adv;
  logic leave_t12;

  always_comb begin
    ring_legal = (ring_q != '0) && ((ring_q & (ring_q - RING_T01)) == '0);
    adv        = (RUN | SSTEP) & ~(INSTOP & ring_q[NTP-1]);
    leave_t12  = adv & ring_q[NTP-1];
  end

  // fresh_q marks an entry from reset/GOJAM so the following T01 does not pulse MCTEND.
  always_comb begin
    ring_d   = ring_q;
    st_d     = st_q;
    pend1_d  = pend1_q | ST1D;
    pend2_d  = pend2_q | ST2D;
    mctend_d = 1'b0;
    fresh_d  = fresh_q;
    if (GOJAM) begin
      ring_d  = RING_T12;
      st_d    = STAGE0;
      pend1_d = 1'b0;
      pend2_d = 1'b0;
      fresh_d = 1'b1;
    end else if (!ring_legal) begin
      ring_d = RING_T12;
    end else begin
      if (adv) begin
        ring_d = {ring_q[NTP-2:0], ring_q[NTP-1]};
      end
      if (leave_t12) begin
        st_d     = stage_e'({pend2_q | ST2D, pend1_q | ST1D});
        pend1_d  = 1'b0;
        pend2_d  = 1'b0;
        mctend_d = ~fresh_q;
        fresh_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      ring_q   <= RING_T12;
      st_q     <= STAGE0;
      pend1_q  <= 1'b0;
      pend2_q  <= 1'b0;
      mctend_q <= 1'b0;
      fresh_q  <= 1'b1;
    end else begin
      ring_q   <= ring_d;
      st_q     <= st_d;
      pend1_q  <= pend1_d;
      pend2_q  <= pend2_d;
      mctend_q <= mctend_d;
      fresh_q  <= fresh_d;
    end
  end

  always_comb begin
    TP_     = ~ring_q;
    T01_    = ~ring_q[0];
    T02     = ring_q[1];
    T07_    = ~ring_q[6];
    T12_    = ~ring_q[NTP-1];
    ST0_    = (st_q != STAGE0);
    ST1_    = (st_q != STAGE1);
    ST3_    = (st_q != STAGE3);
    STD2    = (st_q == STAGE2);
    MCTEND  = mctend_q;
    STOPPED = INSTOP & ring_q[NTP-1];
  end

endmodule

// File: tb/tb_agc_tpgen_stage.sv
// Scoreboard bench for agc_tpgen_stage: a behavioural model pushes expected outputs per CLOCK.
module tb_agc_tpgen_stage;

  logic        CLOCK = 1'b0;
  logic        rst   = 1'b0;
  logic        RUN   = 1'b0;
  logic        SSTEP = 1'b0;
  logic        INSTOP = 1'b0;
  logic        GOJAM = 1'b0;
  logic        ST1D  = 1'b0;
  logic        ST2D  = 1'b0;
  logic [11:0] TP_;
  logic        T01_, T02, T07_, T12_, ST0_, ST1_, ST3_, STD2, MCTEND, STOPPED;

  agc_tpgen_stage #(.NTP(12)) dut (
    .CLOCK(CLOCK), .rst(rst), .RUN(RUN), .SSTEP(SSTEP), .INSTOP(INSTOP),
    .GOJAM(GOJAM), .ST1D(ST1D), .ST2D(ST2D), .TP_(TP_), .T01_(T01_),
    .T02(T02), .T07_(T07_), .T12_(T12_), .ST0_(ST0_), .ST1_(ST1_),
    .ST3_(ST3_), .STD2(STD2), .MCTEND(MCTEND), .STOPPED(STOPPED)
  );

  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: current pulse number 1..12, or an explicit illegal pattern in m_bad.
  int          m_tp;
  logic [11:0] m_bad;
  logic [1:0]  m_st;
  logic        m_p1, m_p2, m_mct, m_fresh;

  logic [21:0] exp_q[$];

  localparam logic [21:0] RESET_VEC = {12'h7FF, 1'b1, 1'b0, 1'b1, 1'b0,
                                       1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  function automatic logic [21:0] obs_vec();
    return {TP_, T01_, T02, T07_, T12_, ST0_, ST1_, ST3_, STD2, MCTEND, STOPPED};
  endfunction

  function automatic logic [21:0] exp_vec();
    logic [11:0] one, r, tpv;
    one = 12'd1;
    r   = (m_bad != 12'd0) ? m_bad : (one << (m_tp - 1));
    tpv = ~r;
    return {tpv, tpv[0], r[1], tpv[6], tpv[11],
            (m_st != 2'd0), (m_st != 2'd1), (m_st != 2'd3), (m_st == 2'd2),
            m_mct, INSTOP & r[11]};
  endfunction

  task automatic model_reset();
    m_tp = 12; m_bad = '0; m_st = 2'd0;
    m_p1 = 1'b0; m_p2 = 1'b0; m_mct = 1'b0; m_fresh = 1'b1;
  endtask

  task automatic step(input logic run, input logic ss, input logic ins,
                      input logic gj, input logic d1, input logic d2);
    logic adv;
    RUN = run; SSTEP = ss; INSTOP = ins; GOJAM = gj; ST1D = d1; ST2D = d2;
    adv = (run | ss) && !(ins && m_bad == 12'd0 && m_tp == 12);
    if (gj) begin
      model_reset();
    end else if (m_bad != 12'd0) begin
      m_bad = '0; m_tp = 12; m_mct = 1'b0;
      m_p1 = m_p1 | d1; m_p2 = m_p2 | d2;
    end else if (adv && m_tp == 12) begin
      m_tp = 1;
      m_st = {m_p2 | d2, m_p1 | d1};
      m_p1 = 1'b0; m_p2 = 1'b0;
      m_mct = !m_fresh; m_fresh = 1'b0;
    end else begin
      if (adv) m_tp = m_tp + 1;
      m_p1 = m_p1 | d1; m_p2 = m_p2 | d2;
      m_mct = 1'b0;
    end
    exp_q.push_back(exp_vec());
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset();
    logic [21:0] got;
    rst = 1'b0; INSTOP = 1'b1;
    model_reset();
    #12;
    n_checks++;
    if (STOPPED !== 1'b1) begin
      n_fail++; $display("FAIL reset_stopped: got %b expected 1", STOPPED);
    end
    INSTOP = 1'b0;
    #1;
    got = obs_vec();
    n_checks++;
    if (got !== RESET_VEC) begin
      n_fail++; $display("FAIL reset_values: got %h expected %h", got, RESET_VEC);
    end
    @(posedge CLOCK); #1;
    rst = 1'b1;
  endtask

  task automatic test_free_run();
    logic [21:0] got, expv;
    int mct_hits = 0;
    for (int i = 1; i <= 25; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
      got = obs_vec(); expv = exp_q.pop_front();
      n_checks++;
      if (got !== expv) begin
        n_fail++; $display("FAIL free_run cyc%0d: got %h expected %h", i, got, expv);
      end
      if (MCTEND === 1'b1) mct_hits++;
      if (i == 13 || i == 25) begin
        n_checks++;
        if (MCTEND !== 1'b1 || T01_ !== 1'b0) begin
          n_fail++; $display("FAIL free_run_mctend cyc%0d: got MCTEND=%b T01_=%b expected 1/0", i, MCTEND, T01_);
        end
      end
    end
    n_checks++;
    if (mct_hits != 2) begin
      n_fail++; $display("FAIL free_run_mct_count: got %0d expected 2", mct_hits);
    end
  endtask

  task automatic test_stage_request();
    logic [21:0] got, expv;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (i < 12) && (m_tp == 5));
      got = obs_vec(); expv = exp_q.pop_front();
      n_checks++;
      if (got !== expv) begin
        n_fail++; $display("FAIL stage_req cyc%0d: got %h expected %h", i, got, expv);
      end
      if (i == 11) begin
        n_checks++;
        if (STD2 !== 1'b1 || ST0_ !== 1'b1 || T01_ !== 1'b0) begin
          n_fail++; $display("FAIL stage_req_mct2: got STD2=%b ST0_=%b T01_=%b expected 1/1/0", STD2, ST0_, T01_);
        end
      end
      if (i == 23) begin
        n_checks++;
        if (ST0_ !== 1'b0) begin
          n_fail++; $display("FAIL stage_req_mct3: got ST0_=%b expected 0", ST0_);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] got, expv;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, (i < 12) && (m_tp == 3), (i < 12) && (m_tp == 12));
      got = obs_vec(); expv = exp_q.pop_front();
      n_checks++;
      if (got !== expv) begin
        n_fail++; $display("FAIL b2b cyc%0d: got %h expected %h", i, got, expv);
      end
      if (i == 11) begin
        n_checks++;
        if (ST3_ !== 1'b0 || dut.pend1_q !== 1'b0 || dut.pend2_q !== 1'b0) begin
          n_fail++; $display("FAIL b2b_stage3: got ST3_=%b pend=%b%b expected 0/00", ST3_, dut.pend2_q, dut.pend1_q);
        end
      end
      if (i == 23) begin
        n_checks++;
        if (ST0_ !== 1'b0) begin
          n_fail++; $display("FAIL b2b_return0: got ST0_=%b expected 0", ST0_);
        end
      end
    end
  endtask

  task automatic test_gojam();
    logic [21:0] got, expv;
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, (i < 12) ? (m_tp == 12) : (m_tp == 3), (i < 12) && (m_tp == 12));
      got = obs_vec(); expv = exp_q.pop_front();
      n_checks++;
      if (got !== expv) begin
        n_fail++; $display("FAIL gojam_setup cyc%0d: got %h expected %h", i, got, expv);
      end
    end
    n_checks++;
    if (T07_ !== 1'b0 || ST3_ !== 1'b0 || dut.pend1_q !== 1'b1) begin
      n_fail++; $display("FAIL gojam_pre: got T07_=%b ST3_=%b pend1=%b expected 0/0/1", T07_, ST3_, dut.pend1_q);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    got = obs_vec(); expv = exp_q.pop_front();
    n_checks++;
    if (got !== expv || TP_ !== 12'h7FF || ST0_ !== 1'b0) begin
      n_fail++; $display("FAIL gojam_hit: got %h expected %h", got, expv);
    end
    for (int i = 0; i < 13; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      got = obs_vec(); expv = exp_q.pop_front();
      n_checks++;
      if (got !== expv) begin
        n_fail++; $display("FAIL gojam_after cyc%0d: got %h expected %h", i, got, expv);
      end
      if (i == 0) begin
        n_checks++;
        if (T01_ !== 1'b0 || MCTEND !== 1'b0 || ST0_ !== 1'b0) begin
          n_fail++; $display("FAIL gojam_first_t01: got T01_=%b MCTEND=%b ST0_=%b expected 0/0/0", T01_, MCTEND, ST0_);
        end
      end
    end
  endtask

  task automatic test_sstep_instop();
    logic [21:0] got, expv;
    for (int i = 0; i < 12 && m_tp != 12; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      void'(exp_q.pop_front());
    end
    n_checks++;
    if (T12_ !== 1'b0) begin
      n_fail++; $display("FAIL sstep_at_t12: got T12_=%b expected 0", T12_);
    end
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++) begin
        step(1'b0, (k == 0), 1'b0, 1'b0, 1'b0, 1'b0);
        got = obs_vec(); expv = exp_q.pop_front();
        n_checks++;
        if (got !== expv || dut.ring_q !== (12'd1 << p)) begin
          n_fail++; $display("FAIL sstep p%0d k%0d: got %h ring %h expected %h", p, k, got, dut.ring_q, expv);
        end
      end
    end
    for (int i = 0; i < 12 && m_tp != 11; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      void'(exp_q.pop_front());
    end
    for (int k = 0; k < 4; k++) begin
      step((k == 2), (k != 2), 1'b1, 1'b0, 1'b0, 1'b0);
      got = obs_vec(); expv = exp_q.pop_front();
      n_checks++;
      if (got !== expv || STOPPED !== 1'b1 || T12_ !== 1'b0) begin
        n_fail++; $display("FAIL instop k%0d: got %h STOPPED=%b expected %h", k, got, STOPPED, expv);
      end
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    got = obs_vec(); expv = exp_q.pop_front();
    n_checks++;
    if (got !== expv || T01_ !== 1'b0 || STOPPED !== 1'b0) begin
      n_fail++; $display("FAIL instop_resume: got %h expected %h", got, expv);
    end
  endtask

  task automatic test_illegal_ring();
    logic [21:0] got, expv;
    logic [11:0] bad;
    bad = 12'b0000_0100_0001;
    force dut.ring_q = bad;
    #1;
    release dut.ring_q;
    m_bad = bad;
    n_checks++;
    if (TP_ !== ~bad) begin
      n_fail++; $display("FAIL illegal_forced: got %h expected %h", TP_, ~bad);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      got = obs_vec(); expv = exp_q.pop_front();
      n_checks++;
      if (got !== expv || (i == 0 && TP_ !== 12'h7FF)) begin
        n_fail++; $display("FAIL illegal_recover cyc%0d: got %h expected %h", i, got, expv);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [21:0] got, expv;
    for (int i = 0; i < 12 && m_tp != 6; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      void'(exp_q.pop_front());
    end
    RUN = 1'b0; ST1D = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    got = obs_vec();
    n_checks++;
    if (got !== RESET_VEC || dut.pend1_q !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got %h pend1=%b expected %h/0", got, dut.pend1_q, RESET_VEC);
    end
    @(posedge CLOCK); #1;
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    got = obs_vec(); expv = exp_q.pop_front();
    n_checks++;
    if (got !== expv || T01_ !== 1'b0 || MCTEND !== 1'b0 || ST0_ !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_t01: got %h expected %h", got, expv);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_free_run();
    test_stage_request();
    test_back_to_back();
    test_gojam();
    test_sstep_instop();
    test_illegal_ring();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/agc_tpgen_stage.md
# agc_tpgen_stage

Time-pulse generator and stage register for the Block II sequence-generator path. Once per memory cycle (MCT) it produces the twelve one-hot time pulses T01–T12. It also holds the 2-bit instruction stage (ST1, ST2), which it updates only at the T12→T01 boundary. It sits directly upstream of the SQ-register/instruction-decode tray, which consumes T01_, T02, T07_, T12_, ST0_, ST1_, ST3_ and STD2. Its own stage-set requests come back from the crosspoint logic downstream of that tray.

## Interface
Parameters:
- NTP, 12, number of time pulses per MCT; fixed at 12 for AGC compatibility, ring width follows it.

Ports:
- CLOCK in 1: single system clock; every state change occurs on its rising edge.
- rst in 1: reset, asynchronous and active-low.
- RUN in 1: 1 = advance one time pulse per CLOCK; 0 = hold.
- SSTEP in 1: single-step strobe, one CLOCK wide; honoured only while RUN=0.
- INSTOP in 1: when 1, freeze at end of T12 (do not enter T01).
- GOJAM in 1: synchronous restart.
- ST1D in 1: request ST1=1 for the next MCT.
- ST2D in 1: request ST2=1 for the next MCT.
- TP_ out NTP: active-low one-hot time pulses; bit k-1 = Tk_.
- T01_ out 1: alias of TP_[0].
- T02 out 1: active-high T02.
- T07_ out 1: alias of TP_[6].
- T12_ out 1: alias of TP_[11].
- ST0_ out 1: low when stage = 0.
- ST1_ out 1: low when stage = 1.
- ST3_ out 1: low when stage = 3.
- STD2 out 1: high when stage = 2.
- MCTEND out 1: one-CLOCK pulse on each T12→T01 transition.
- STOPPED out 1: high while INSTOP is holding the ring at T12.

## Operation
- Ring: one-hot register ring[NTP-1:0]. Current pulse Tk means ring[k-1]=1. TP_ = ~ring.
- Advance condition: adv = (RUN | SSTEP) & ~(INSTOP & ring[11]). On adv the ring rotates Tk→Tk+1 and T12→T01.
- Stage register: st = {ST2, ST1} encodes stage = 2·ST2 + ST1.
  - Outputs are combinational from st: ST0_ = ~(st==0), ST1_ = ~(st==1), STD2 = (st==2), ST3_ = ~(st==3).
- Pending requests: pend1 and pend2 set when ST1D or ST2D, respectively, is 1 on any CLOCK while not in GOJAM. They are sticky until the transfer.
- Transfer: on the adv edge that leaves T12, st ← {pend2|ST2D, pend1|ST1D}, and pend1 and pend2 clear. A request on that same edge counts.
- No requests at transfer → stage returns to 0.
- MCTEND is registered. It is 1 for exactly the CLOCK cycle in which the ring holds T01 after a T12→T01 advance.
- STOPPED = INSTOP & ring[11], combinational.
- GOJAM (synchronous, highest priority): ring ← T12, st ← 0, pend ← 0, MCTEND ← 0. The first pulse after GOJAM drops is T01, and that T01 does not pulse MCTEND.
- Illegal ring state (not one-hot, e.g. SEU): the next CLOCK forces ring ← T12 regardless of adv. The block never stays in an illegal state.

## Timing
- Reset values (rst low, asynchronous):
  - ring = T12, so TP_ = 12'h7FF with bit 11 = 0.
  - T12_ = 0, T01_ = 1, T02 = 0, T07_ = 1.
  - st = 0, so ST0_ = 0, ST1_ = 1, ST3_ = 1, STD2 = 0.
  - pend = 0, MCTEND = 0, STOPPED = INSTOP.
- The first RUN edge after reset release enters T01. It does not pulse MCTEND, because the reset entry is treated like GOJAM.
- Free-running MCT with RUN=1 is exactly NTP CLOCKs.
- Stage outputs change on the same edge the ring enters T01. Decode sees the new stage from T01 onward.
- SSTEP while RUN=1 has no extra effect: at most one advance per CLOCK.
- INSTOP asserted mid-MCT lets the ring run to T12 and then hold. Deasserting it resumes with T01 on the next adv.
- GOJAM concurrent with ST1D/ST2D or the T12 transfer: GOJAM wins and the requests are lost.
- rst asserted mid-MCT clears everything immediately, with no dependence on CLOCK.

## Test plan
- Reset then RUN=1 for 25 CLOCKs → TP_ walks T01..T12, T01..T12, T01. MCTEND is high only on cycle 13 (second T01) and cycle 25. ST0_ stays 0 throughout.
- ST2D pulsed during T05 of MCT1 → in MCT2 at T01, STD2=1 and ST0_=1. In MCT3 with no request, ST0_=0.
- ST1D at T03 plus ST2D on the T12 transfer edge → next MCT ST3_=0 and pend clears. A following MCT with no requests returns to stage 0.
- RUN=0 and three SSTEP pulses spaced 4 CLOCKs apart from T12 → T01, T02, T03, with the ring held in between. With INSTOP=1 at T11, one step reaches T12, STOPPED=1, and a further SSTEP does not move the ring.
- GOJAM at T07 with stage=3 and pend1 set → next CLOCK ring=T12 and ST0_=0. After GOJAM drops, the next MCT is stage 0 and the first T01 has MCTEND=0.
- Force ring to 12'b0000_0100_0001 via a bench force and release → next CLOCK ring=T12. rst asserted mid-T06 → outputs take their reset values with no CLOCK edge.
